// File: rtl/argmax_result_unit.sv
// Output stage after the last dense layer: captures the packed output vector, finds the index
// of the largest signed element by serial scan and raises a sticky result-ready interrupt.
module argmax_result_unit #(
  parameter int unsigned NUM_INPUTS = 10,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned IDX_WIDTH  = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] i_data,
  input  logic                             i_valid,
  output logic                             o_busy,
  output logic [IDX_WIDTH-1:0]             o_index,
  output logic [DATA_WIDTH-1:0]            o_max,
  output logic                             o_valid,
  output logic                             intr,
  input  logic                             intr_clr,
  output logic                             o_overrun
);

  localparam int unsigned CntW = $clog2(NUM_INPUTS) + 1;
  localparam int unsigned SelW = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;

  typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

  state_e                state_q;
  logic [CntW-1:0]       cnt_q;
  logic [DATA_WIDTH-1:0] elem_q [NUM_INPUTS];
  logic [DATA_WIDTH-1:0] max_q;
  logic [IDX_WIDTH-1:0]  idx_q;
  logic                  busy_q;
  logic                  valid_q;
  logic                  intr_q;
  logic                  overrun_q;
  logic [IDX_WIDTH-1:0]  index_q;
  logic [DATA_WIDTH-1:0] out_max_q;
  logic [DATA_WIDTH-1:0] cur_elem;

  assign cur_elem = elem_q[cnt_q[SelW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      max_q     <= '0;
      idx_q     <= '0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      intr_q    <= 1'b0;
      overrun_q <= 1'b0;
      index_q   <= '0;
      out_max_q <= '0;
      for (int unsigned n = 0; n < NUM_INPUTS; n++) begin
        elem_q[n] <= '0;
      end
    end else begin
      valid_q <= 1'b0;

      // A set in the same cycle as a clear takes priority.
      if (i_valid && busy_q) begin
        overrun_q <= 1'b1;
      end else if (intr_clr) begin
        overrun_q <= 1'b0;
      end

      if (state_q == StDone) begin
        intr_q <= 1'b1;
      end else if (intr_clr) begin
        intr_q <= 1'b0;
      end

      unique case (state_q)
        StIdle: begin
          if (i_valid) begin
            for (int unsigned n = 0; n < NUM_INPUTS; n++) begin
              elem_q[n] <= i_data[n*DATA_WIDTH +: DATA_WIDTH];
            end
            max_q   <= i_data[DATA_WIDTH-1:0];
            idx_q   <= '0;
            cnt_q   <= CntW'(1);
            busy_q  <= 1'b1;
            state_q <= (NUM_INPUTS == 1) ? StDone : StScan;
          end
        end
        StScan: begin
          // Strictly greater only, so ties keep the lower index.
          if ($signed(cur_elem) > $signed(max_q)) begin
            max_q <= cur_elem;
            idx_q <= IDX_WIDTH'(cnt_q);
          end
          cnt_q <= cnt_q + CntW'(1);
          if (cnt_q == CntW'(NUM_INPUTS - 1)) begin
            state_q <= StDone;
          end
        end
        StDone: begin
          index_q   <= idx_q;
          out_max_q <= max_q;
          valid_q   <= 1'b1;
          busy_q    <= 1'b0;
          state_q   <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign o_busy    = busy_q;
  assign o_index   = index_q;
  assign o_max     = out_max_q;
  assign o_valid   = valid_q;
  assign intr      = intr_q;
  assign o_overrun = overrun_q;

endmodule
